vram_sram_responder: RTL



---
 rtl/vram_sram_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vram_sram_responder.sv
// VRAM arbiter-bus responder: captures one request per dot slot into a small
// queue and plays it out on a 16-bit asynchronous SRAM. Reads are returned to
// the display path and complete the CPU / command toggle handshakes. In
// vdp_super mode the main slot becomes a two-word (32-bit) burst read.
module vram_sram_responder #(
    parameter int SRAM_AW    = 19,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               CLK21M,
    input  logic               RESET,
    input  logic [1:0]         DOTSTATE,
    input  logic               vdp_super,
    input  logic [19:0]        IRAMADR,
    input  logic [7:0]         PRAMDBO_8,
    input  logic               PRAMWE_N,
    input  logic               VDPVRAMREADINGR,
    input  logic               vdp_cmd_vram_reading_req,
    output logic               VDPVRAMREADINGA,
    output logic [7:0]         VDPVRAMRDDATA,
    output logic               vdp_cmd_vram_reading_ack,
    output logic [7:0]         vdp_cmd_vram_rd_data,
    output logic               rd_valid,
    output logic               rd_slot,
    output logic [7:0]         rd_data_8,
    output logic [15:0]        rd_data_16,
    output logic [31:0]        rd_data_32,
    output logic               overrun,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [19:0] addr;
        logic        we_n;
        logic [7:0]  data;
        logic        slot;
        logic        cpu;
        logic        cmd;
        logic        burst;
    } req_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DONE,
        B_SETUP1,
        B_DONE1
    } state_t;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    logic main_slot;
    logic sec_slot;
    logic push_req;
    req_t push_entry;

    // Build the entry for this slot; CPU/command reads only ride the main slot.
    always_comb begin
        main_slot        = (DOTSTATE == 2'b11);
        sec_slot         = (DOTSTATE == 2'b10) && PRAMWE_N && !vdp_super;
        push_req         = main_slot || sec_slot;
        push_entry.addr  = IRAMADR;
        push_entry.we_n  = PRAMWE_N;
        push_entry.data  = PRAMDBO_8;
        push_entry.slot  = !main_slot;
        push_entry.cpu   = main_slot && (VDPVRAMREADINGR != VDPVRAMREADINGA);
        push_entry.cmd   = main_slot && (vdp_cmd_vram_reading_req != vdp_cmd_vram_reading_ack);
        push_entry.burst = main_slot && vdp_super;
    end

    // ------------------------------------------------------------------
    // Request queue (pointers carry one wrap bit to tell full from empty)
    // ------------------------------------------------------------------
    logic [PW:0] wr_ptr_reg;
    logic [PW:0] rd_ptr_reg;
    req_t        fifo_mem [FIFO_DEPTH];
    req_t        head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push_ok;
    logic        pop;
    logic        overrun_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                        (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign push_ok    = push_req && !fifo_full;
    assign head       = fifo_mem[rd_ptr_reg[PW-1:0]];

    // Queue storage; contents need no reset since the pointers qualify them.
    always_ff @(posedge CLK21M) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[PW-1:0]] <= push_entry;
        end
    end

    // Queue pointers and the sticky drop flag.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_req && fifo_full) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM access FSM with registered strobes
    // ------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [SRAM_AW-1:0]  addr_reg, addr_next;
    logic [15:0]         dq_o_reg, dq_o_next;
    logic                dq_oe_reg, dq_oe_next;
    logic                ce_n_reg, ce_n_next;
    logic                oe_n_reg, oe_n_next;
    logic                we_n_reg, we_n_next;
    logic                ub_n_reg, ub_n_next;
    logic                lb_n_reg, lb_n_next;

    // Fields of the entry currently on the SRAM
    logic cur_a0_reg;
    logic cur_we_n_reg;
    logic cur_slot_reg;
    logic cur_cpu_reg;
    logic cur_cmd_reg;
    logic cur_burst_reg;

    logic        start_access;
    logic        bus_release;
    logic [18:0] head_word;

    // Next-state and next-strobe logic; starting an access pops the queue head.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        dq_o_next    = dq_o_reg;
        dq_oe_next   = dq_oe_reg;
        ce_n_next    = ce_n_reg;
        oe_n_next    = oe_n_reg;
        we_n_next    = we_n_reg;
        ub_n_next    = ub_n_reg;
        lb_n_next    = lb_n_reg;
        pop          = 1'b0;
        start_access = 1'b0;
        bus_release  = 1'b0;
        head_word    = head.addr[19:1];
        if (head.burst && head.we_n) begin
            head_word[0] = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    start_access = 1'b1;
                end
            end
            SETUP: begin
                state_next = DONE;
                // Write pulse is a single clock; data stays driven through DONE for hold.
                if (!cur_we_n_reg) begin
                    we_n_next = 1'b1;
                end
            end
            DONE: begin
                if (cur_burst_reg) begin
                    state_next = B_SETUP1;
                    addr_next  = addr_reg + SRAM_AW'(1);
                end else if (!fifo_empty) begin
                    start_access = 1'b1;
                end else begin
                    bus_release = 1'b1;
                end
            end
            B_SETUP1: begin
                state_next = B_DONE1;
                oe_n_next  = 1'b0;
            end
            B_DONE1: begin
                if (!fifo_empty) begin
                    start_access = 1'b1;
                end else begin
                    bus_release = 1'b1;
                end
            end
            default: begin
                bus_release = 1'b1;
            end
        endcase

        if (bus_release) begin
            state_next = IDLE;
            ce_n_next  = 1'b1;
            oe_n_next  = 1'b1;
            we_n_next  = 1'b1;
            ub_n_next  = 1'b1;
            lb_n_next  = 1'b1;
            dq_oe_next = 1'b0;
        end

        if (start_access) begin
            pop        = 1'b1;
            state_next = SETUP;
            addr_next  = SRAM_AW'(head_word);
            ce_n_next  = 1'b0;
            if (head.we_n) begin
                oe_n_next  = 1'b0;
                we_n_next  = 1'b1;
                ub_n_next  = 1'b0;
                lb_n_next  = 1'b0;
                dq_oe_next = 1'b0;
            end else begin
                // Both lanes carry the byte; only the addressed lane is strobed.
                oe_n_next  = 1'b1;
                we_n_next  = 1'b0;
                ub_n_next  = !head.addr[0];
                lb_n_next  = head.addr[0];
                dq_oe_next = 1'b1;
                dq_o_next  = {head.data, head.data};
            end
        end
    end

    // FSM state, SRAM strobes and the in-flight entry.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            dq_o_reg      <= '0;
            dq_oe_reg     <= 1'b0;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            ub_n_reg      <= 1'b1;
            lb_n_reg      <= 1'b1;
            cur_a0_reg    <= 1'b0;
            cur_we_n_reg  <= 1'b1;
            cur_slot_reg  <= 1'b0;
            cur_cpu_reg   <= 1'b0;
            cur_cmd_reg   <= 1'b0;
            cur_burst_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            dq_o_reg  <= dq_o_next;
            dq_oe_reg <= dq_oe_next;
            ce_n_reg  <= ce_n_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            ub_n_reg  <= ub_n_next;
            lb_n_reg  <= lb_n_next;
            if (pop) begin
                cur_a0_reg    <= head.addr[0];
                cur_we_n_reg  <= head.we_n;
                cur_slot_reg  <= head.slot;
                cur_cpu_reg   <= head.cpu;
                cur_cmd_reg   <= head.cmd;
                cur_burst_reg <= head.burst && head.we_n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read completion
    // ------------------------------------------------------------------
    logic        rd_done;
    logic [7:0]  lane_byte;
    logic [15:0] word0_reg;
    logic        rd_valid_reg;
    logic        rd_slot_reg;
    logic [7:0]  rd_data_8_reg;
    logic [15:0] rd_data_16_reg;
    logic [31:0] rd_data_32_reg;
    logic        readinga_reg;
    logic [7:0]  cpu_data_reg;
    logic        cmd_ack_reg;
    logic [7:0]  cmd_data_reg;

    assign rd_done   = ((state_reg == DONE) && cur_we_n_reg && !cur_burst_reg) ||
                       (state_reg == B_DONE1);
    assign lane_byte = cur_a0_reg ? sram_dq_i[15:8] : sram_dq_i[7:0];

    // Latch returned data, pulse rd_valid and toggle whichever handshakes asked.
    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            word0_reg      <= '0;
            rd_valid_reg   <= 1'b0;
            rd_slot_reg    <= 1'b0;
            rd_data_8_reg  <= '0;
            rd_data_16_reg <= '0;
            rd_data_32_reg <= '0;
            readinga_reg   <= 1'b0;
            cpu_data_reg   <= '0;
            cmd_ack_reg    <= 1'b0;
            cmd_data_reg   <= '0;
        end else begin
            rd_valid_reg <= rd_done;
            if ((state_reg == DONE) && cur_burst_reg) begin
                word0_reg <= sram_dq_i;
            end
            if (rd_done) begin
                rd_slot_reg    <= cur_slot_reg;
                rd_data_16_reg <= sram_dq_i;
                rd_data_8_reg  <= lane_byte;
                if (state_reg == B_DONE1) begin
                    rd_data_32_reg <= {sram_dq_i, word0_reg};
                end
                if (cur_cpu_reg) begin
                    cpu_data_reg <= lane_byte;
                    readinga_reg <= !readinga_reg;
                end
                if (cur_cmd_reg) begin
                    cmd_data_reg <= lane_byte;
                    cmd_ack_reg  <= !cmd_ack_reg;
                end
            end
        end
    end

    assign sram_addr                = addr_reg;
    assign sram_dq_o                = dq_o_reg;
    assign sram_dq_oe               = dq_oe_reg;
    assign sram_ce_n                = ce_n_reg;
    assign sram_oe_n                = oe_n_reg;
    assign sram_we_n                = we_n_reg;
    assign sram_ub_n                = ub_n_reg;
    assign sram_lb_n                = lb_n_reg;
    assign rd_valid                 = rd_valid_reg;
    assign rd_slot                  = rd_slot_reg;
    assign rd_data_8                = rd_data_8_reg;
    assign rd_data_16               = rd_data_16_reg;
    assign rd_data_32               = rd_data_32_reg;
    assign VDPVRAMREADINGA          = readinga_reg;
    assign VDPVRAMRDDATA            = cpu_data_reg;
    assign vdp_cmd_vram_reading_ack = cmd_ack_reg;
    assign vdp_cmd_vram_rd_data     = cmd_data_reg;
    assign overrun                  = overrun_reg;

endmodule
